// File: rtl/decode_register_stage.sv
// rtl/decode_register_stage.sv - RV32I R/I-type ALU decode, 32x32 register file and bring-up counters
module decode_register_stage #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            Instruction_code,
    input  logic [31:0]            wb_data,
    output logic [31:0]            rs1_data,
    output logic [31:0]            rs2_data,
    output logic [31:0]            imm,
    output logic                   alu_src_imm,
    output logic [3:0]             alu_control,
    output logic                   reg_write,
    output logic                   illegal,
    input  logic [4:0]             dbg_addr,
    output logic [31:0]            dbg_data,
    output logic [COUNT_WIDTH-1:0] instr_count,
    output logic [COUNT_WIDTH-1:0] illegal_count
);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_STD = 7'b0000000;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;

    assign opcode = Instruction_code[6:0];
    assign rd     = Instruction_code[11:7];
    assign funct3 = Instruction_code[14:12];
    assign rs1    = Instruction_code[19:15];
    assign rs2    = Instruction_code[24:20];
    assign funct7 = Instruction_code[31:25];

    assign imm = {{20{Instruction_code[31]}}, Instruction_code[31:20]};

    logic       legal;
    logic [3:0] ctrl;
    logic       src_imm;

    always_comb begin
        legal   = 1'b0;
        ctrl    = ALU_ADD;
        src_imm = 1'b0;
        unique case (opcode)
            OP_REG: begin
                if (funct7 == F7_STD) begin
                    legal = 1'b1;
                    unique case (funct3)
                        3'b000:  ctrl = ALU_ADD;
                        3'b001:  ctrl = ALU_SLL;
                        3'b010:  ctrl = ALU_SLT;
                        3'b011:  ctrl = ALU_SLTU;
                        3'b100:  ctrl = ALU_XOR;
                        3'b101:  ctrl = ALU_SRL;
                        3'b110:  ctrl = ALU_OR;
                        default: ctrl = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000) begin
                        legal = 1'b1;
                        ctrl  = ALU_SUB;
                    end else if (funct3 == 3'b101) begin
                        legal = 1'b1;
                        ctrl  = ALU_SRA;
                    end
                end
            end
            OP_IMM: begin
                src_imm = 1'b1;
                unique case (funct3)
                    3'b000: begin legal = 1'b1; ctrl = ALU_ADD;  end
                    3'b010: begin legal = 1'b1; ctrl = ALU_SLT;  end
                    3'b011: begin legal = 1'b1; ctrl = ALU_SLTU; end
                    3'b100: begin legal = 1'b1; ctrl = ALU_XOR;  end
                    3'b110: begin legal = 1'b1; ctrl = ALU_OR;   end
                    3'b111: begin legal = 1'b1; ctrl = ALU_AND;  end
                    3'b001: begin
                        legal = (funct7 == F7_STD);
                        ctrl  = ALU_SLL;
                    end
                    default: begin
                        // funct3 101: funct7 chooses logical vs arithmetic shift
                        legal = (funct7 == F7_STD) || (funct7 == F7_ALT);
                        ctrl  = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    end
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    assign illegal     = ~legal;
    assign reg_write   = legal;
    assign alu_control = legal ? ctrl : ALU_ADD;
    assign alu_src_imm = legal & src_imm;

    logic [31:0] regs_q [32];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_write && (rd != 5'd0)) begin
            regs_q[rd] <= wb_data;
        end
    end

    // x0 is forced to zero at the read mux rather than relying on storage
    assign rs1_data = (rs1 == 5'd0)      ? 32'd0 : regs_q[rs1];
    assign rs2_data = (rs2 == 5'd0)      ? 32'd0 : regs_q[rs2];
    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs_q[dbg_addr];

    logic [COUNT_WIDTH-1:0] instr_count_q;
    logic [COUNT_WIDTH-1:0] instr_count_d;
    logic [COUNT_WIDTH-1:0] illegal_count_q;
    logic [COUNT_WIDTH-1:0] illegal_count_d;

    always_comb begin
        instr_count_d   = instr_count_q + COUNT_WIDTH'(1);
        illegal_count_d = illegal_count_q;
        if (illegal) begin
            illegal_count_d = illegal_count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count_q   <= '0;
            illegal_count_q <= '0;
        end else begin
            instr_count_q   <= instr_count_d;
            illegal_count_q <= illegal_count_d;
        end
    end

    assign instr_count   = instr_count_q;
    assign illegal_count = illegal_count_q;

endmodule

// File: tb/tb_decode_register_stage.sv
// tb/tb_decode_register_stage.sv - scoreboard bench for decode_register_stage
module tb_decode_register_stage;

    logic        clk;
    logic        reset;
    logic [31:0] Instruction_code;
    logic [31:0] wb_data;
    logic [4:0]  dbg_addr;

    logic [31:0] rs1_data, rs2_data, imm, dbg_data;
    logic        alu_src_imm, reg_write, illegal;
    logic [3:0]  alu_control;
    logic [31:0] instr_count, illegal_count;

    logic [31:0] n_rs1_data, n_rs2_data, n_imm, n_dbg_data;
    logic        n_alu_src_imm, n_reg_write, n_illegal;
    logic [3:0]  n_alu_control;
    logic [3:0]  n_instr_count, n_illegal_count;

    decode_register_stage #(.COUNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .Instruction_code(Instruction_code), .wb_data(wb_data),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .alu_src_imm(alu_src_imm),
        .alu_control(alu_control), .reg_write(reg_write), .illegal(illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .instr_count(instr_count), .illegal_count(illegal_count)
    );

    decode_register_stage #(.COUNT_WIDTH(4)) dut_narrow (
        .clk(clk), .reset(reset), .Instruction_code(Instruction_code), .wb_data(wb_data),
        .rs1_data(n_rs1_data), .rs2_data(n_rs2_data), .imm(n_imm), .alu_src_imm(n_alu_src_imm),
        .alu_control(n_alu_control), .reg_write(n_reg_write), .illegal(n_illegal),
        .dbg_addr(dbg_addr), .dbg_data(n_dbg_data),
        .instr_count(n_instr_count), .illegal_count(n_illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int S_RS1 = 0, S_RS2 = 1, S_IMM = 2, S_SRC = 3, S_CTRL = 4, S_RW = 5,
                   S_ILL = 6, S_DBG = 7, S_ICNT = 8, S_LCNT = 9, S_NICNT = 10, S_NLCNT = 11;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_RS1:   return rs1_data;
            S_RS2:   return rs2_data;
            S_IMM:   return imm;
            S_SRC:   return {31'd0, alu_src_imm};
            S_CTRL:  return {28'd0, alu_control};
            S_RW:    return {31'd0, reg_write};
            S_ILL:   return {31'd0, illegal};
            S_DBG:   return dbg_data;
            S_ICNT:  return instr_count;
            S_LCNT:  return illegal_count;
            S_NICNT: return {28'd0, n_instr_count};
            default: return {28'd0, n_illegal_count};
        endcase
    endfunction

    task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        q.push_back(c);
    endtask

    task automatic expect_decode(input string name, input logic [3:0] ctrl, input logic src,
                                 input logic ill);
        expect_val({name, ".ctrl"}, S_CTRL, {28'd0, ctrl});
        expect_val({name, ".src"},  S_SRC,  {31'd0, src});
        expect_val({name, ".ill"},  S_ILL,  {31'd0, ill});
        expect_val({name, ".rw"},   S_RW,   {31'd0, ~ill});
    endtask

    task automatic expect_counts(input string name, input logic [31:0] icnt, input logic [31:0] lcnt);
        expect_val({name, ".icnt"},  S_ICNT,  icnt);
        expect_val({name, ".lcnt"},  S_LCNT,  lcnt);
        expect_val({name, ".nicnt"}, S_NICNT, {28'd0, icnt[3:0]});
        expect_val({name, ".nlcnt"}, S_NLCNT, {28'd0, lcnt[3:0]});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: the DUT presents combinational results every cycle; compare at the falling edge
    always @(negedge clk) begin
        while (q.size() > 0) begin
            chk_t        c;
            logic [31:0] act;
            c   = q.pop_front();
            act = observe(c.sel);
            n_checks++;
            if (act !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
            end
        end
    end

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  ctrl;
        logic        src;
        logic        ill;
        string       name;
    } dec_vec_t;

    dec_vec_t dvec[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset            = 1'b1;
        Instruction_code = 32'h0000_0013;
        wb_data          = 32'd0;
        dbg_addr         = 5'd0;
        cyc();
        cyc();

        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            expect_val($sformatf("sweep.x%0d", a), S_DBG, 32'd0);
            if (a == 0) expect_counts("rst", 32'd0, 32'd0);
            cyc();
        end

        // Decode table exercised while reset holds the counters and registers still
        dvec.push_back('{32'h0000_0013, 4'b0000, 1'b1, 1'b0, "nop_addi"});
        dvec.push_back('{32'h4000_5033, 4'b0111, 1'b0, 1'b0, "sra"});
        dvec.push_back('{32'h0000_1033, 4'b0010, 1'b0, 1'b0, "sll"});
        dvec.push_back('{32'h0000_6033, 4'b1000, 1'b0, 1'b0, "or"});
        dvec.push_back('{32'h0000_7033, 4'b1001, 1'b0, 1'b0, "and"});
        dvec.push_back('{32'h0000_3013, 4'b0100, 1'b1, 1'b0, "sltiu"});
        dvec.push_back('{32'h0000_5013, 4'b0110, 1'b1, 1'b0, "srli"});
        dvec.push_back('{32'h4000_5013, 4'b0111, 1'b1, 1'b0, "srai"});
        dvec.push_back('{32'h4000_1013, 4'b0000, 1'b0, 1'b1, "slli_bad_f7"});
        dvec.push_back('{32'h0200_0033, 4'b0000, 1'b0, 1'b1, "r_bad_f7"});
        dvec.push_back('{32'h0000_0000, 4'b0000, 1'b0, 1'b1, "op_zero"});
        foreach (dvec[i]) begin
            Instruction_code = dvec[i].instr;
            expect_decode(dvec[i].name, dvec[i].ctrl, dvec[i].src, dvec[i].ill);
            cyc();
        end
        expect_counts("rst_hold", 32'd0, 32'd0);
        cyc();

        // ADDI x5,x0,-1
        reset            = 1'b0;
        Instruction_code = 32'hFFF0_0293;
        wb_data          = 32'hFFFF_FFFF;
        dbg_addr         = 5'd5;
        expect_val("addi.imm", S_IMM, 32'hFFFF_FFFF);
        expect_decode("addi", 4'b0000, 1'b1, 1'b0);
        expect_val("addi.x5_pre", S_DBG, 32'd0);
        expect_counts("addi", 32'd0, 32'd0);
        cyc();

        // SUB x6,x5,x5: x5 visible after the edge, x6 still old this cycle
        Instruction_code = 32'h4052_8333;
        wb_data          = 32'h1234_5678;
        dbg_addr         = 5'd6;
        expect_decode("sub", 4'b0001, 1'b0, 1'b0);
        expect_val("sub.rs1", S_RS1, 32'hFFFF_FFFF);
        expect_val("sub.rs2", S_RS2, 32'hFFFF_FFFF);
        expect_val("sub.x6_pre", S_DBG, 32'd0);
        expect_counts("sub", 32'd1, 32'd0);
        cyc();

        // ADDI x0,x0,5
        Instruction_code = 32'h0050_0013;
        wb_data          = 32'd5;
        dbg_addr         = 5'd6;
        expect_val("x6_post", S_DBG, 32'h1234_5678);
        expect_val("addi0.imm", S_IMM, 32'd5);
        expect_val("addi0.rs1", S_RS1, 32'd0);
        expect_val("addi0.rw", S_RW, 32'd1);
        cyc();

        // Illegal: funct7=0100000 with funct3=010
        Instruction_code = 32'h4052_A333;
        wb_data          = 32'hDEAD_BEEF;
        dbg_addr         = 5'd0;
        expect_val("x0_after_write", S_DBG, 32'd0);
        expect_decode("ill_r", 4'b0000, 1'b0, 1'b1);
        expect_val("ill_r.rs1", S_RS1, 32'hFFFF_FFFF);
        expect_counts("ill_r", 32'd3, 32'd0);
        cyc();

        // Illegal: opcode 0x7F with rd=x6
        Instruction_code = 32'h0000_037F;
        dbg_addr         = 5'd6;
        expect_decode("ill_op", 4'b0000, 1'b0, 1'b1);
        expect_val("ill_op.x6", S_DBG, 32'h1234_5678);
        expect_counts("ill_op", 32'd4, 32'd1);
        cyc();

        Instruction_code = 32'h0000_0013;
        wb_data          = 32'd0;
        expect_val("after_ill.x6", S_DBG, 32'h1234_5678);
        expect_counts("after_ill", 32'd5, 32'd2);
        for (int k = 0; k < 11; k++) cyc();
        expect_counts("wrap", 32'd16, 32'd2);
        cyc();

        // Reset in the same cycle as a legal write to x7
        reset            = 1'b1;
        Instruction_code = 32'h0010_0393;
        wb_data          = 32'hAAAA_5555;
        cyc();
        reset            = 1'b0;
        Instruction_code = 32'h0000_0013;
        dbg_addr         = 5'd7;
        expect_val("rst_wr.x7", S_DBG, 32'd0);
        expect_counts("rst_wr", 32'd0, 32'd0);
        cyc();
        dbg_addr = 5'd5;
        expect_val("rst_wr.x5", S_DBG, 32'd0);
        expect_counts("post_rst", 32'd1, 32'd0);
        cyc();

        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_register_stage.md
# decode_register_stage

Decode and register-file stage of the single-cycle RV32I core, directly downstream of instruction fetch. Consumes the 32-bit instruction word each cycle and decodes the integer R-type and I-type ALU instructions into ALU control, an immediate and operand-select signals. Holds the 32×32 architectural register file: combinational reads for rs1/rs2, and a clocked write-back of the ALU result to rd. Also keeps retired and illegal instruction counters for bring-up and verification.

## Interface
Parameters:
- COUNT_WIDTH, 32, width of the `instr_count` and `illegal_count` counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- Instruction_code  input  32  instruction word from fetch for the current cycle.
- wb_data  input  32  ALU result to write back to rd this cycle.
- rs1_data  output  32  register[rs1], combinational.
- rs2_data  output  32  register[rs2], combinational.
- imm  output  32  sign-extended I-type immediate (Instruction_code[31:20]).
- alu_src_imm  output  1  1 selects imm as ALU operand B; 0 selects rs2_data.
- alu_control  output  4  ALU operation code.
- reg_write  output  1  current instruction writes rd.
- illegal  output  1  current instruction is not supported.
- dbg_addr  input  5  debug read address.
- dbg_data  output  32  register[dbg_addr], combinational.
- instr_count  output  COUNT_WIDTH  cycles retired since reset.
- illegal_count  output  COUNT_WIDTH  illegal instructions since reset.

## Operation
- Fields: opcode=[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25].
- alu_control: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND.
- R-type (opcode 0110011, alu_src_imm=0):
  - funct7=0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7=0100000: funct3 000 SUB, 101 SRA; any other funct3 is illegal.
  - Any other funct7 is illegal.
- I-type ALU (opcode 0010011, alu_src_imm=1):
  - funct3 000 ADDI, 010 SLTI, 011 SLTIU, 100 XORI, 110 ORI, 111 ANDI.
  - 001 SLLI requires funct7=0000000.
  - 101 requires funct7=0000000 (SRLI) or 0100000 (SRAI).
  - Any other funct7 on a shift is illegal.
- Any other opcode is illegal.
- When illegal: reg_write=0, alu_control=ADD, alu_src_imm=0.
- imm is always driven from [31:20], sign-extended, regardless of opcode.
- reg_write = legal instruction.
- Register file is 32 entries of 32 bits.
  - x0 always reads 0 on rs1, rs2 and dbg ports; writes to x0 are discarded.
  - Reads return the pre-edge contents; there is no write-to-read bypass, so a same-cycle read of rd returns the old value.
- Counters wrap modulo 2^COUNT_WIDTH.
  - instr_count increments every non-reset cycle.
  - illegal_count increments on every non-reset cycle with illegal=1.

## Timing
- Decode outputs and register reads are purely combinational from Instruction_code and current state; zero latency.
- Write-back: at a rising edge with reset=0, reg_write=1 and rd≠0, register[rd] ← wb_data. The value is visible on the read ports immediately after that edge.
- Reset: at a rising edge with reset=1, all 31 writable registers, instr_count and illegal_count clear to 0. Reset dominates any pending write.
  - After reset, rs1_data, rs2_data and dbg_data read 0.
  - Decode outputs follow Instruction_code even during reset (they are combinational).
- Reset asserted mid-program discards that cycle's write and counter increments.
- Counter wrap: instr_count=2^COUNT_WIDTH−1 followed by one active cycle gives 0.

## Test plan
- Reset, then dbg_addr sweep 0..31 -> dbg_data=0 for every entry; both counters = 0.
- ADDI x5,x0,-1 (0xFFF00293), wb_data=0xFFFFFFFF -> imm=0xFFFFFFFF, alu_src_imm=1, alu_control=0000, reg_write=1; after the edge, dbg_addr=5 reads 0xFFFFFFFF.
- SUB x6,x5,x5 (0x40528333) -> alu_control=0001, rs1_data=rs2_data=0xFFFFFFFF; same-cycle read of x6 returns the old value, and x6 updates only after the edge.
- ADDI x0,x0,5 (0x00500013), wb_data=5 -> x0 still reads 0 on all ports.
- 0x4052A333 (funct7=0100000, funct3=010) and opcode 0x7F -> illegal=1, reg_write=0, no register changes, illegal_count increments by 2.
- Assert reset in the same cycle as a valid write to x7 -> x7 stays 0 and the counters read 0. With COUNT_WIDTH=4, 16 active cycles -> instr_count wraps to 0.
